// File: rtl/jt12_interpol_mc.sv
// Multi-channel CIC interpolator for the JT12 mixer path.
// Comb on cen_in, injector/integrators/output on cen_out.
module jt12_interpol_mc #(
  parameter int CH    = 2,
  parameter int INW   = 16,
  parameter int CALCW = 24,
  parameter int N     = 2,
  parameter int M     = 1,
  parameter int RATEW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen_in,
  input  logic              cen_out,
  input  logic [RATEW-1:0]  rate_m1,
  input  logic              hold,
  input  logic [3:0]        shift,
  input  logic              clr_sat,
  input  logic [CH*INW-1:0] snd_in,
  output logic [CH*INW-1:0] snd_out,
  output logic              out_valid,
  output logic [CH-1:0]     sat_flag
);

  typedef logic signed [CALCW-1:0] calc_t;
  typedef logic signed [INW-1:0]   samp_t;

  localparam samp_t OMAX = {1'b0, {(INW-1){1'b1}}};
  localparam samp_t OMIN = {1'b1, {(INW-1){1'b0}}};
  localparam calc_t VMAX = {{(CALCW-INW){1'b0}}, OMAX};
  localparam calc_t VMIN = {{(CALCW-INW){1'b1}}, OMIN};

  calc_t cdl_q   [CH][N][M];
  calc_t cdl_d   [CH][N][M];
  calc_t cmb_q   [CH][N];
  calc_t cmb_d   [CH][N];
  calc_t integ_q [CH][N];
  calc_t integ_d [CH][N];
  calc_t inj_q   [CH];
  calc_t inj_d   [CH];
  samp_t out_q   [CH];
  samp_t out_d   [CH];

  logic [CH-1:0]    sat_q, sat_d;
  logic             vld_q, vld_d;
  logic [RATEW-1:0] phase_q, phase_d;
  logic [RATEW-1:0] rate_q, rate_d;
  logic             fresh_q, fresh_d;

  // Next-state: comb, phase/rate, injector, integrators, saturating output
  always_comb begin
    calc_t            x;
    calc_t            v;
    logic [RATEW-1:0] rate_eff;
    x        = '0;
    v        = '0;
    cdl_d    = cdl_q;
    cmb_d    = cmb_q;
    integ_d  = integ_q;
    inj_d    = inj_q;
    out_d    = out_q;
    phase_d  = phase_q;
    rate_d   = rate_q;
    fresh_d  = fresh_q;
    vld_d    = cen_out;
    sat_d    = sat_q & ~{CH{clr_sat}};
    // Until the first cen_out, the live rate input stands in for rate_act
    rate_eff = fresh_q ? rate_m1 : rate_q;

    if (cen_in) begin
      for (int c = 0; c < CH; c++) begin
        x = {{(CALCW-INW){snd_in[c*INW+INW-1]}},
             snd_in[c*INW +: INW]};
        cmb_d[c][0] = x - cdl_q[c][0][M-1];
        cdl_d[c][0][0] = x;
        for (int j = 1; j < M; j++)
          cdl_d[c][0][j] = cdl_q[c][0][j-1];
        for (int k = 1; k < N; k++) begin
          x = cmb_q[c][k-1];
          cmb_d[c][k] = x - cdl_q[c][k][M-1];
          cdl_d[c][k][0] = x;
          for (int j = 1; j < M; j++)
            cdl_d[c][k][j] = cdl_q[c][k][j-1];
        end
      end
    end

    if (cen_out) begin
      fresh_d = 1'b0;
      if (phase_q == rate_eff) begin
        phase_d = '0;
        rate_d  = rate_m1;
      end else begin
        phase_d = phase_q + RATEW'(1);
        rate_d  = rate_eff;
      end
      for (int c = 0; c < CH; c++) begin
        if (hold || phase_q == '0)
          inj_d[c] = cmb_q[c][N-1];
        else
          inj_d[c] = '0;
        integ_d[c][0] = integ_q[c][0] + inj_q[c];
        for (int k = 1; k < N; k++)
          integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
        v = integ_q[c][N-1] >>> shift;
        if (v > VMAX) begin
          out_d[c] = OMAX;
          sat_d[c] = 1'b1;
        end else if (v < VMIN) begin
          out_d[c] = OMIN;
          sat_d[c] = 1'b1;
        end else begin
          out_d[c] = v[INW-1:0];
        end
      end
    end
  end

  // State registers, all cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdl_q   <= '{default: '0};
      cmb_q   <= '{default: '0};
      integ_q <= '{default: '0};
      inj_q   <= '{default: '0};
      out_q   <= '{default: '0};
      sat_q   <= '0;
      vld_q   <= 1'b0;
      phase_q <= '0;
      rate_q  <= '0;
      fresh_q <= 1'b1;
    end else begin
      cdl_q   <= cdl_d;
      cmb_q   <= cmb_d;
      integ_q <= integ_d;
      inj_q   <= inj_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      fresh_q <= fresh_d;
    end
  end

  genvar g;
  for (g = 0; g < CH; g++) begin : g_pack
    assign snd_out[g*INW +: INW] = out_q[g];
  end

  assign out_valid = vld_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_jt12_interpol_mc.sv
// Directed self-checking bench for jt12_interpol_mc.
// Impulse, hold, saturation, negative DC, rate change, reset.
module tb_jt12_interpol_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen_in;
  logic        cen_out;
  logic [2:0]  rate_m1;
  logic        hold;
  logic [3:0]  shift;
  logic        clr_sat;
  logic [31:0] snd_in;
  logic [31:0] snd_out;
  logic        out_valid;
  logic [1:0]  sat_flag;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_zs [12] = '{100, 200, 300, 400, 300, 200,
                      100, 0, 0, 0, 0, 0};
  int exp_hd [12] = '{100, 300, 600, 1000, 1200, 1200,
                      1000, 600, 300, 100, 0, 0};

  always #5 clk = ~clk;

  jt12_interpol_mc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen_in    (cen_in),
    .cen_out   (cen_out),
    .rate_m1   (rate_m1),
    .hold      (hold),
    .shift     (shift),
    .clr_sat   (clr_sat),
    .snd_in    (snd_in),
    .snd_out   (snd_out),
    .out_valid (out_valid),
    .sat_flag  (sat_flag)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic tick(input logic ci,
                      input logic [15:0] a0,
                      input logic [15:0] a1);
    cen_in = ci;
    snd_in = {a1, a0};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    cen_in  = 1'b0;
    cen_out = 1'b0;
    clr_sat = 1'b0;
    snd_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_impulse(input logic hv,
                             input int e [12],
                             input string tag);
    int   got [48];
    int   first;
    logic ch1_nz;
    logic vld_all;
    first   = -1;
    ch1_nz  = 1'b0;
    vld_all = 1'b1;
    hold    = hv;
    rate_m1 = 3'd3;
    shift   = 4'd0;
    cen_out = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick(i % 4 == 0, (i == 0) ? 16'd100 : 16'd0, 16'd0);
      got[i] = int'($signed(snd_out[15:0]));
      if (snd_out[31:16] != 16'd0) ch1_nz = 1'b1;
      if (out_valid !== 1'b1) vld_all = 1'b0;
    end
    for (int i = 0; i < 48; i++)
      if (first < 0 && got[i] != 0) first = i;
    chk({tag, "_lat"}, 32'(first >= 0 && first <= 36), 32'd1);
    if (first >= 0 && first <= 36)
      for (int k = 0; k < 12; k++)
        chk($sformatf("%s_s%0d", tag, k),
            got[first+k], e[k]);
    chk({tag, "_ch1"}, 32'(ch1_nz), 32'd0);
    chk({tag, "_vld"}, 32'(vld_all), 32'd1);
    cen_out = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    cen_in  = 1'b0;
    cen_out = 1'b0;
    rate_m1 = 3'd3;
    hold    = 1'b0;
    shift   = 4'd0;
    clr_sat = 1'b0;
    snd_in  = '0;

    // reset state
    do_reset();
    chk("rst_out", snd_out, 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);

    // zero-stuff and hold impulses
    run_impulse(1'b0, exp_zs, "zs");
    do_reset();
    run_impulse(1'b1, exp_hd, "hd");

    // mid-stream asynchronous reset
    do_reset();
    hold    = 1'b0;
    rate_m1 = 3'd3;
    shift   = 4'd0;
    cen_out = 1'b1;
    for (int i = 0; i < 14; i++)
      tick(i % 4 == 0, (i == 0) ? 16'd100 : 16'd0, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out", snd_out, 32'd0);
    chk("mrst_sat", 32'(sat_flag), 32'd0);
    chk("mrst_vld", 32'(out_valid), 32'd0);
    cen_out = 1'b0;
    cen_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_impulse(1'b0, exp_zs, "rerun");

    // saturation and sticky flag
    do_reset();
    rate_m1 = 3'd3;
    hold    = 1'b0;
    shift   = 4'd0;
    cen_out = 1'b1;
    for (int i = 0; i < 40; i++)
      tick(i % 4 == 0, 16'h7fff, 16'h7fff);
    chk("sat_ch0", 32'(snd_out[15:0]), 32'h7fff);
    chk("sat_ch1", 32'(snd_out[31:16]), 32'h7fff);
    chk("sat_flag", 32'(sat_flag), 32'd3);
    shift   = 4'd2;
    clr_sat = 1'b1;
    tick(1'b0, 16'h7fff, 16'h7fff);
    clr_sat = 1'b0;
    for (int i = 0; i < 8; i++)
      tick(i % 4 == 0, 16'h7fff, 16'h7fff);
    chk("sh2_ch0", 32'(snd_out[15:0]), 32'h7fff);
    chk("sh2_ch1", 32'(snd_out[31:16]), 32'h7fff);
    chk("sh2_flag", 32'(sat_flag), 32'd0);
    shift = 4'd0;
    for (int i = 0; i < 3; i++)
      tick(1'b0, 16'h7fff, 16'h7fff);
    chk("resat_flag", 32'(sat_flag), 32'd3);
    clr_sat = 1'b1;
    tick(1'b0, 16'h7fff, 16'h7fff);
    clr_sat = 1'b0;
    chk("setwins", 32'(sat_flag), 32'd3);

    // negative DC on channel 1
    do_reset();
    rate_m1 = 3'd7;
    shift   = 4'd3;
    hold    = 1'b0;
    cen_out = 1'b1;
    for (int i = 0; i < 80; i++)
      tick(i % 8 == 0, 16'd0, 16'hfc18);
    chk("neg_ch1", 32'(snd_out[31:16]), 32'hfc18);
    chk("neg_ch0", 32'(snd_out[15:0]), 32'd0);
    chk("neg_flag", 32'(sat_flag), 32'd0);

    // rate change takes effect only at phase wrap
    do_reset();
    rate_m1 = 3'd3;
    hold    = 1'b0;
    shift   = 4'd0;
    tick(1'b1, 16'd100, 16'd0);
    tick(1'b1, 16'd100, 16'd0);
    chk("rc_novld", 32'(out_valid), 32'd0);
    cen_out = 1'b1;
    tick(1'b0, 16'd0, 16'd0);
    chk("rc_ph1", 32'(dut.phase_q), 32'd1);
    chk("rc_inj1", 32'(dut.inj_q[0]), 32'd100);
    tick(1'b0, 16'd0, 16'd0);
    chk("rc_ph2", 32'(dut.phase_q), 32'd2);
    rate_m1 = 3'd1;
    begin
      int eph [6];
      int einj [6];
      eph  = '{3, 0, 1, 0, 1, 0};
      einj = '{0, 0, 100, 0, 100, 0};
      for (int k = 0; k < 6; k++) begin
        tick(1'b0, 16'd0, 16'd0);
        chk($sformatf("rc_ph_%0d", k),
            32'(dut.phase_q), eph[k]);
        chk($sformatf("rc_inj_%0d", k),
            32'(dut.inj_q[0]), einj[k]);
      end
    end
    cen_out = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jt12_interpol_mc.md
Name: jt12_interpol_mc

Overview:
- Multi-channel, runtime-configurable CIC interpolator for the JT12 mixer path.
- Upsamples CH signed channels from the cen_in rate to the cen_out rate using N comb stages of depth M and N integrator stages.
- Adds a runtime rate, zero-stuff or sample-hold injection, runtime gain shift, output saturation with a sticky flag, and an output-valid strobe.
- Sits between the FM/PSG/ADPCM mixers and the DAC or sample-rate output stage.

Parameters:
- CH, 2, number of independent channels, packed channel 0 at LSBs
- INW, 16, input/output sample width per channel, signed
- CALCW, 24, internal width; must be >= INW + N*ceil(log2(MAXRATE*M)) + 1
- N, 2, number of comb and integrator stages
- M, 1, comb differential delay, in cen_in ticks
- RATEW, 3, width of rate_m1; maximum rate is 2^RATEW

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen_in  in  1  input-rate clock enable; comb section advances
- cen_out  in  1  output-rate clock enable; injector, integrators and output advance
- rate_m1  in  RATEW  interpolation rate minus 1 (0 → rate 1)
- hold  in  1  0 = zero-stuff injection, 1 = sample-hold injection
- shift  in  4  arithmetic right shift applied before saturation
- clr_sat  in  1  synchronous clear of sat_flag
- snd_in  in  CH*INW  packed signed input samples
- snd_out  out  CH*INW  packed signed output samples, registered
- out_valid  out  1  one-clk pulse when snd_out updates
- sat_flag  out  CH  sticky per-channel saturation flag

Behaviour:
- Reset: asynchronous, active-low (rst_n low clears immediately). Clears all comb delay lines, injector, integrators, snd_out, sat_flag, out_valid and phase; loads rate_act with rate_m1. An assertion mid-operation discards all history, and the first output afterwards is computed from zero state.
- Comb, per channel, on cen_in: input is sign-extended to CALCW. Each stage is registered: y <= x - x[n-M]. Comb latency is N cen_in ticks.
- Phase counter, on cen_out: phase counts 0..rate_act, then wraps to 0. rate_m1 is sampled into rate_act only when phase wraps to 0; changes in between have no effect until the next wrap.
- Injector, registered, on cen_out:
  - hold=0: inj <= comb_op when phase==0, else 0.
  - hold=1: inj <= comb_op on every cen_out.
  - hold is read each cen_out.
- Same-clk cen_in and cen_out: the injector takes the comb output value present before that edge (old value); no combinational bypass.
- Integrators, on cen_out: stage k <= stage k + stage k-1, with stage 0 = inj. Arithmetic is modular at CALCW bits; wrap is intentional and must not saturate.
- Output stage, on cen_out:
  - v = integ_N >>> shift (arithmetic).
  - If v > 2^(INW-1)-1, output max positive and set sat_flag[c].
  - If v < -2^(INW-1), output max negative and set sat_flag[c].
  - Otherwise output v[INW-1:0].
- Pipeline latency: snd_out reflects inj after N+1 cen_out ticks (injector, N integrators, output register).
- out_valid: asserted high for exactly one clk on each cycle where cen_out is high and rst_n is high.
- sat_flag: sticky. clr_sat clears it. If clr_sat and a new saturation occur on the same clk, the flag is set (set wins).
- Rate 1 (rate_m1=0): phase stays 0. Both modes are identical and behave as a plain comb/integrator pair with gain M^N.
- Channels share phase, rate_act, hold and shift. There is no cross-channel arithmetic.

Test Plan:
1. Zero-stuff impulse, CH0. N=2, M=1, rate_m1=3, hold=0, shift=0, one cen_out per clk, cen_in every 4th clk. Drive snd_in=100 for one cen_in, then 0 → after latency, snd_out ch0 = 100,200,300,400,300,200,100,0, then 0 steady; channel 1 stays 0; out_valid pulses every clk.
2. Hold-mode impulse, same setup with hold=1 → ch0 = 100,300,600,1000,1200,1200,1000,600,300,100,0.
3. Saturation. DC input 0x7FFF on both channels, rate 4, shift=0 → steady snd_out 0x7FFF, sat_flag=2'b11. Repeat with shift=2 and clr_sat pulsed → steady 0x7FFF, sat_flag stays 0. Pulse clr_sat on a saturating cycle → flag remains 1.
4. Negative DC. Input -1000 on ch1, rate 8, shift=3 → steady ch1 = -1000, no saturation.
5. Rate change. Switch rate_m1 from 3 to 1 while phase==2 → injection pattern unchanged until phase wraps; afterwards nonzero injection occurs every 2nd cen_out.
6. Mid-stream reset. Pull rst_n low between clk edges during test 1 → snd_out=0, sat_flag=0, out_valid=0 immediately, with no clk edge needed. After release, the output sequence restarts from zero state.
